// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 configuration sequencer:
// register map, TX mode encoding, status source codes and FSM states.
package tlk2711_pkg;

    // Register map of the tlk2711_top register port
    localparam logic [15:0] TX_CTRL = 16'h0100;
    localparam logic [15:0] TX_BASE = 16'h0108;
    localparam logic [15:0] TX_LEN  = 16'h0110;
    localparam logic [15:0] TX_SEG  = 16'h0118;
    localparam logic [15:0] TX_CFG  = 16'h0120;
    localparam logic [15:0] RX_CTRL = 16'h0200;
    localparam logic [15:0] RX_BASE = 16'h0208;
    localparam logic [15:0] LOSS    = 16'h0300;

    typedef enum logic [1:0] {
        MODE_NORM  = 2'd0,
        MODE_LOOP  = 2'd1,
        MODE_KCODE = 2'd2
    } tx_mode_e;

    // Interrupt source codes reported on o_status_src
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_TX   = 2'd1;
    localparam logic [1:0] SRC_RX   = 2'd2;
    localparam logic [1:0] SRC_LOSS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WAIT_IRQ = 3'd2,
        ST_RD       = 3'd3,
        ST_CLR      = 3'd4,
        ST_FIN      = 3'd5
    } seq_state_e;

    // IRQ status register that belongs to a given source
    function automatic logic [15:0] irq_addr(input logic [1:0] src);
        case (src)
            SRC_TX:  irq_addr = TX_CTRL;
            SRC_RX:  irq_addr = RX_CTRL;
            default: irq_addr = LOSS;
        endcase
    endfunction

endpackage

// File: rtl/tlk2711_cfg_sequencer.sv
// Hardware sequencer for the tlk2711_top register port: programs one
// transfer descriptor, starts TX (and optionally RX), services the IRQs by
// reading their status registers and reports completion or timeout.
module tlk2711_cfg_sequencer
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH     = 40,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_desc_valid,
    output logic                  o_desc_ready,
    input  logic [ADDR_WIDTH-1:0] i_tx_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_rx_base_addr,
    input  logic [31:0]           i_tx_total,
    input  logic [31:0]           i_tx_body,
    input  logic [31:0]           i_tx_tail,
    input  logic [31:0]           i_tx_body_num,
    input  logic [1:0]            i_tx_mode,
    input  logic                  i_rx_en,
    output logic                  o_reg_wen,
    output logic [15:0]           o_reg_waddr,
    output logic [63:0]           o_reg_wdata,
    output logic                  o_reg_ren,
    output logic [15:0]           o_reg_raddr,
    input  logic [63:0]           i_reg_rdata,
    input  logic                  i_tx_irq,
    input  logic                  i_rx_irq,
    input  logic                  i_loss_irq,
    output logic                  o_busy,
    output logic                  o_status_valid,
    output logic [63:0]           o_status,
    output logic [1:0]            o_status_src,
    output logic                  o_done,
    output logic                  o_err
);

    seq_state_e state, state_next;

    logic [ADDR_WIDTH-1:0] tx_base, rx_base;
    logic [31:0]           tx_total, tx_body, tx_tail, tx_body_num;
    tx_mode_e              tx_mode;
    logic                  rx_en;

    logic [2:0]  wr_idx;
    logic [31:0] tcnt;
    logic [2:0]  rd_cnt;
    logic [3:0]  clr_cnt;
    logic        tx_done, rx_done, abort;
    logic [1:0]  src;

    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [2:0]  wr_last;
    logic [1:0]  pick;
    logic        timeout_hit, rd_capture, src_level, clr_exit, all_done;

    // Write table: one register per index, RX start only when enabled
    always_comb begin
        wr_addr = TX_CTRL;
        wr_data = 64'd0;
        case (wr_idx)
            3'd0: begin wr_addr = TX_BASE; wr_data = 64'(tx_base);                     end
            3'd1: begin wr_addr = RX_BASE; wr_data = 64'(rx_base);                     end
            3'd2: begin wr_addr = TX_LEN;  wr_data = {32'd0, tx_total};                end
            3'd3: begin wr_addr = TX_SEG;  wr_data = {tx_tail, tx_body};               end
            3'd4: begin wr_addr = TX_CFG;  wr_data = {tx_body_num, 30'd0, 2'(tx_mode)}; end
            3'd5: begin wr_addr = TX_CTRL; wr_data = 64'd0;                            end
            3'd6: begin wr_addr = RX_CTRL; wr_data = 64'd0;                            end
            default: begin wr_addr = TX_CTRL; wr_data = 64'd0;                         end
        endcase
    end

    // IRQ arbitration (tx > rx > loss, only sources not yet serviced) and exit conditions
    always_comb begin
        pick = SRC_NONE;
        if (i_tx_irq && !tx_done)
            pick = SRC_TX;
        else if (i_rx_irq && rx_en && !rx_done)
            pick = SRC_RX;
        else if (i_loss_irq)
            pick = SRC_LOSS;

        case (src)
            SRC_TX:   src_level = i_tx_irq;
            SRC_RX:   src_level = i_rx_irq;
            SRC_LOSS: src_level = i_loss_irq;
            default:  src_level = 1'b0;
        endcase

        wr_last     = rx_en ? 3'd6 : 3'd5;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));
        rd_capture  = (rd_cnt == 3'(RD_LAT));
        clr_exit    = !src_level || (clr_cnt == 4'd15);
        all_done    = tx_done && (rx_done || !rx_en);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (i_desc_valid) state_next = ST_WR;
            ST_WR:       if (wr_idx == wr_last) state_next = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                if (pick != SRC_NONE)
                    state_next = ST_RD;
                else if (timeout_hit)
                    state_next = ST_FIN;
            end
            ST_RD:       if (rd_capture) state_next = ST_CLR;
            ST_CLR:      if (clr_exit) state_next = all_done ? ST_FIN : ST_WAIT_IRQ;
            ST_FIN:      state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Descriptor capture, register-bus strobes, counters and status capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_base        <= '0;
            rx_base        <= '0;
            tx_total       <= '0;
            tx_body        <= '0;
            tx_tail        <= '0;
            tx_body_num    <= '0;
            tx_mode        <= MODE_NORM;
            rx_en          <= 1'b0;
            wr_idx         <= '0;
            tcnt           <= '0;
            rd_cnt         <= '0;
            clr_cnt        <= '0;
            tx_done        <= 1'b0;
            rx_done        <= 1'b0;
            abort          <= 1'b0;
            src            <= SRC_NONE;
            o_reg_wen      <= 1'b0;
            o_reg_waddr    <= '0;
            o_reg_wdata    <= '0;
            o_reg_ren      <= 1'b0;
            o_reg_raddr    <= '0;
            o_status_valid <= 1'b0;
            o_status       <= '0;
            o_status_src   <= SRC_NONE;
        end else begin
            o_reg_wen      <= 1'b0;
            o_reg_ren      <= 1'b0;
            o_status_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_desc_valid) begin
                        tx_base     <= i_tx_base_addr;
                        rx_base     <= i_rx_base_addr;
                        tx_total    <= i_tx_total;
                        tx_body     <= i_tx_body;
                        tx_tail     <= i_tx_tail;
                        tx_body_num <= i_tx_body_num;
                        tx_mode     <= tx_mode_e'(i_tx_mode);
                        rx_en       <= i_rx_en;
                        wr_idx      <= '0;
                        tx_done     <= 1'b0;
                        rx_done     <= 1'b0;
                        abort       <= 1'b0;
                    end
                end
                ST_WR: begin
                    o_reg_wen   <= 1'b1;
                    o_reg_waddr <= wr_addr;
                    o_reg_wdata <= wr_data;
                    wr_idx      <= wr_idx + 3'd1;
                    if (wr_idx == wr_last)
                        tcnt <= '0;
                end
                ST_WAIT_IRQ: begin
                    tcnt <= tcnt + 32'd1;
                    if (pick != SRC_NONE) begin
                        src         <= pick;
                        o_reg_ren   <= 1'b1;
                        o_reg_raddr <= irq_addr(pick);
                        rd_cnt      <= '0;
                    end else if (timeout_hit) begin
                        abort <= 1'b1;
                    end
                end
                ST_RD: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    if (rd_capture) begin
                        o_status       <= i_reg_rdata;
                        o_status_src   <= src;
                        o_status_valid <= 1'b1;
                        clr_cnt        <= '0;
                        if (src == SRC_TX) tx_done <= 1'b1;
                        if (src == SRC_RX) rx_done <= 1'b1;
                    end
                end
                ST_CLR: begin
                    clr_cnt <= clr_cnt + 4'd1;
                    if (clr_exit && !all_done)
                        tcnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_desc_ready = (state == ST_IDLE);
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_FIN);
    assign o_err        = (state == ST_FIN) && abort;

endmodule

// File: tb/tb_tlk2711_cfg_sequencer.sv
// Self-checking bench for tlk2711_cfg_sequencer: randomized descriptors and
// IRQ scenarios checked against a transaction-level reference model.
module tb_tlk2711_cfg_sequencer;

    localparam int AW  = 40;
    localparam int RDL = 2;
    localparam int TO  = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_desc_valid = 1'b0;
    logic          o_desc_ready;
    logic [AW-1:0] i_tx_base_addr = '0, i_rx_base_addr = '0;
    logic [31:0]   i_tx_total = '0, i_tx_body = '0, i_tx_tail = '0, i_tx_body_num = '0;
    logic [1:0]    i_tx_mode = '0;
    logic          i_rx_en = 1'b0;
    logic          o_reg_wen, o_reg_ren;
    logic [15:0]   o_reg_waddr, o_reg_raddr;
    logic [63:0]   o_reg_wdata, i_reg_rdata;
    logic          i_tx_irq = 1'b0, i_rx_irq = 1'b0, i_loss_irq = 1'b0;
    logic          o_busy, o_status_valid, o_done, o_err;
    logic [63:0]   o_status;
    logic [1:0]    o_status_src;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tlk2711_cfg_sequencer #(
        .ADDR_WIDTH    (AW),
        .RD_LAT        (RDL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_desc_valid  (i_desc_valid),
        .o_desc_ready  (o_desc_ready),
        .i_tx_base_addr(i_tx_base_addr),
        .i_rx_base_addr(i_rx_base_addr),
        .i_tx_total    (i_tx_total),
        .i_tx_body     (i_tx_body),
        .i_tx_tail     (i_tx_tail),
        .i_tx_body_num (i_tx_body_num),
        .i_tx_mode     (i_tx_mode),
        .i_rx_en       (i_rx_en),
        .o_reg_wen     (o_reg_wen),
        .o_reg_waddr   (o_reg_waddr),
        .o_reg_wdata   (o_reg_wdata),
        .o_reg_ren     (o_reg_ren),
        .o_reg_raddr   (o_reg_raddr),
        .i_reg_rdata   (i_reg_rdata),
        .i_tx_irq      (i_tx_irq),
        .i_rx_irq      (i_rx_irq),
        .i_loss_irq    (i_loss_irq),
        .o_busy        (o_busy),
        .o_status_valid(o_status_valid),
        .o_status      (o_status),
        .o_status_src  (o_status_src),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    // Register-file responder: IRQ status contents, returned RDL cycles after a read
    logic [63:0] tx_stat, rx_stat, loss_stat;
    logic [63:0] rpipe [RDL];

    function automatic logic [63:0] reg_val(input logic [15:0] a);
        case (a)
            16'h0100: reg_val = tx_stat;
            16'h0200: reg_val = rx_stat;
            16'h0300: reg_val = loss_stat;
            default:  reg_val = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction

    always @(posedge clk) begin
        rpipe[0] <= o_reg_ren ? reg_val(o_reg_raddr) : {$urandom, $urandom};
        for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign i_reg_rdata = rpipe[RDL-1];

    // Bus monitor: logs every write, read, status pulse and done pulse with its cycle
    typedef struct { logic [15:0] a; logic [63:0] d; int c; } wr_t;
    int          cyc = 0;
    wr_t         wlog[$];
    logic [15:0] rlog[$];
    logic [65:0] slog[$];
    logic        dlog[$];
    int          dcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_reg_wen)      wlog.push_back('{o_reg_waddr, o_reg_wdata, cyc});
            if (o_reg_ren)      rlog.push_back(o_reg_raddr);
            if (o_status_valid) slog.push_back({o_status_src, o_status});
            if (o_done) begin
                dlog.push_back(o_err);
                dcyc.push_back(cyc);
            end
        end
    end

    // Descriptor under test and the expected write sequence derived from it
    logic [AW-1:0] d_txb, d_rxb;
    logic [31:0]   d_total, d_body, d_tail, d_num;
    logic [1:0]    d_mode;
    logic          d_rxen;
    logic [15:0]   exp_a [7];
    logic [63:0]   exp_d [7];
    int            exp_n;

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wlog.delete(); rlog.delete(); slog.delete(); dlog.delete(); dcyc.delete();
    endtask

    task automatic random_desc(input logic rxen);
        d_txb   = AW'({$urandom, $urandom});
        d_rxb   = AW'({$urandom, $urandom});
        d_total = $urandom;
        d_body  = $urandom;
        d_tail  = $urandom;
        d_num   = $urandom;
        d_mode  = 2'($urandom_range(0, 2));
        d_rxen  = rxen;
    endtask

    task automatic model_writes;
        exp_a[0] = 16'h0108; exp_d[0] = {24'd0, d_txb};
        exp_a[1] = 16'h0208; exp_d[1] = {24'd0, d_rxb};
        exp_a[2] = 16'h0110; exp_d[2] = {32'd0, d_total};
        exp_a[3] = 16'h0118; exp_d[3] = {d_tail, d_body};
        exp_a[4] = 16'h0120; exp_d[4] = {d_num, 30'd0, d_mode};
        exp_a[5] = 16'h0100; exp_d[5] = 64'd0;
        exp_a[6] = 16'h0200; exp_d[6] = 64'd0;
        exp_n = d_rxen ? 7 : 6;
    endtask

    task automatic send_desc;
        int w = 0;
        while (!o_desc_ready && w < 100) begin tick; w++; end
        n_vec++;
        if (!o_desc_ready) begin
            n_err++;
            $display("FAIL desc_ready_wait: got %0b expected 1", o_desc_ready);
        end
        i_tx_base_addr = d_txb; i_rx_base_addr = d_rxb;
        i_tx_total = d_total; i_tx_body = d_body; i_tx_tail = d_tail;
        i_tx_body_num = d_num; i_tx_mode = d_mode; i_rx_en = d_rxen;
        i_desc_valid = 1'b1;
        tick;
        i_desc_valid = 1'b0;
        i_tx_base_addr = AW'({$urandom, $urandom}); i_rx_base_addr = AW'({$urandom, $urandom});
        i_tx_total = $urandom; i_tx_body = $urandom; i_tx_tail = $urandom;
        i_tx_body_num = $urandom; i_tx_mode = 2'($urandom); i_rx_en = ~d_rxen;
    endtask

    task automatic check_writes;
        int w = 0;
        while (wlog.size() < exp_n && w < 30) begin tick; w++; end
        repeat (3) tick;
        n_vec++;
        if (wlog.size() != exp_n) begin
            n_err++;
            $display("FAIL write_count: got %0d expected %0d", wlog.size(), exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                n_vec++;
                if (wlog[i].a !== exp_a[i] || wlog[i].d !== exp_d[i] || wlog[i].c != wlog[0].c + i) begin
                    n_err++;
                    $display("FAIL write_%0d: got addr %0h data %0h cyc +%0d expected addr %0h data %0h cyc +%0d",
                             i, wlog[i].a, wlog[i].d, wlog[i].c - wlog[0].c, exp_a[i], exp_d[i], i);
                end
            end
        end
    endtask

    task automatic set_irq(input int which, input logic v);
        case (which)
            1: i_tx_irq = v;
            2: i_rx_irq = v;
            default: i_loss_irq = v;
        endcase
    endtask

    task automatic service(input int which, input logic [1:0] exp_src, input logic [15:0] exp_addr);
        int  n0 = slog.size();
        int  r0 = rlog.size();
        bit  got = 0;
        set_irq(which, 1'b1);
        for (int i = 0; i < 40 && !got; i++) begin
            tick;
            if (slog.size() > n0) got = 1;
        end
        set_irq(which, 1'b0);
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL status_src%0d: got no status pulse expected src %0d", exp_src, exp_src);
        end else begin
            if (slog[n0] !== {exp_src, reg_val(exp_addr)}) begin
                n_err++;
                $display("FAIL status_src%0d: got %0h expected %0h", exp_src, slog[n0], {exp_src, reg_val(exp_addr)});
            end
            n_vec++;
            if (rlog.size() != r0 + 1 || rlog[r0] !== exp_addr) begin
                n_err++;
                $display("FAIL read_addr_src%0d: got %0d reads last %0h expected 1 read at %0h",
                         exp_src, rlog.size() - r0, (rlog.size() > r0) ? rlog[r0] : 16'hFFFF, exp_addr);
            end
        end
    endtask

    task automatic wait_done(input logic exp_err);
        int w = 0;
        while (dlog.size() == 0 && w < 200) begin tick; w++; end
        n_vec++;
        if (dlog.size() != 1 || dlog[0] !== exp_err) begin
            n_err++;
            $display("FAIL done: got %0d pulses err %0b expected 1 pulse err %0b",
                     dlog.size(), (dlog.size() > 0) ? dlog[0] : 1'bx, exp_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        n_vec++;
        if ({o_desc_ready, o_busy, o_reg_wen, o_reg_ren, o_status_valid, o_done, o_err} !== 7'b1000000 ||
            o_status !== 64'd0 || o_status_src !== 2'd0 || o_reg_waddr !== 16'd0 || o_reg_wdata !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy %0b busy %0b wen %0b ren %0b sv %0b done %0b err %0b st %0h src %0d expected rdy 1 others 0",
                     o_desc_ready, o_busy, o_reg_wen, o_reg_ren, o_status_valid, o_done, o_err, o_status, o_status_src);
        end
        rst_n = 1'b1;
        repeat (2) tick;
    endtask

    task automatic test_desc(input bit fixed, input logic rxen, input bit with_loss);
        int nr;
        clear_logs();
        tx_stat = {$urandom, $urandom}; rx_stat = {$urandom, $urandom}; loss_stat = {$urandom, $urandom};
        random_desc(rxen);
        if (fixed) begin
            d_txb = 'h0; d_rxb = 'h100; d_total = 1800; d_body = 870; d_tail = 60; d_num = 2; d_mode = 0;
        end
        model_writes();
        send_desc();
        check_writes();
        n_vec++;
        if (o_busy !== 1'b1 || o_desc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_wait: got busy %0b ready %0b expected busy 1 ready 0", o_busy, o_desc_ready);
        end
        i_desc_valid = 1'b1;
        tick;
        i_desc_valid = 1'b0;
        if (with_loss) service(3, 2'd3, 16'h0300);
        if (!rxen) begin
            i_rx_irq = 1'b1;
            repeat (5) tick;
        end
        service(1, 2'd1, 16'h0100);
        if (rxen) service(2, 2'd2, 16'h0200);
        wait_done(1'b0);
        tick;
        i_rx_irq = 1'b0;
        nr = 1 + (rxen ? 1 : 0) + (with_loss ? 1 : 0);
        n_vec++;
        if (rlog.size() != nr || slog.size() != nr || wlog.size() != exp_n || o_desc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL desc_totals: got reads %0d status %0d writes %0d ready %0b expected %0d %0d %0d 1",
                     rlog.size(), slog.size(), wlog.size(), o_desc_ready, nr, nr, exp_n);
        end
    endtask

    task automatic test_simultaneous;
        int w = 0;
        clear_logs();
        tx_stat = {$urandom, $urandom}; rx_stat = {$urandom, $urandom};
        random_desc(1'b1);
        model_writes();
        send_desc();
        check_writes();
        i_tx_irq = 1'b1;
        i_rx_irq = 1'b1;
        while (slog.size() < 2 && w < 80) begin tick; w++; end
        i_tx_irq = 1'b0;
        i_rx_irq = 1'b0;
        n_vec++;
        if (slog.size() < 2 || slog[0] !== {2'd1, tx_stat} || slog[1] !== {2'd2, rx_stat}) begin
            n_err++;
            $display("FAIL simul_status: got %0d pulses first %0h expected src1 %0h then src2 %0h",
                     slog.size(), (slog.size() > 0) ? slog[0] : 66'h0, tx_stat, rx_stat);
        end
        n_vec++;
        if (rlog.size() != 2 || rlog[0] !== 16'h0100 || rlog[1] !== 16'h0200) begin
            n_err++;
            $display("FAIL simul_reads: got %0d reads first %0h expected 0100 then 0200",
                     rlog.size(), (rlog.size() > 0) ? rlog[0] : 16'hFFFF);
        end
        wait_done(1'b0);
        tick;
    endtask

    task automatic test_timeout;
        int last;
        clear_logs();
        random_desc(1'($urandom));
        model_writes();
        send_desc();
        check_writes();
        last = (wlog.size() > 0) ? wlog[wlog.size()-1].c : 0;
        wait_done(1'b1);
        n_vec++;
        if (dcyc.size() == 0 || dcyc[0] - last != TO) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d expected %0d", (dcyc.size() > 0) ? dcyc[0] - last : -1, TO);
        end
        tick;
        n_vec++;
        if (o_desc_ready !== 1'b1 || rlog.size() != 0 || wlog.size() != exp_n) begin
            n_err++;
            $display("FAIL timeout_after: got ready %0b reads %0d writes %0d expected 1 0 %0d",
                     o_desc_ready, rlog.size(), wlog.size(), exp_n);
        end
    endtask

    task automatic test_reset_mid;
        int w = 0;
        clear_logs();
        random_desc(1'b1);
        model_writes();
        send_desc();
        while (wlog.size() < 3 && w < 30) begin tick; w++; end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_desc_ready, o_busy, o_reg_wen, o_reg_ren, o_status_valid, o_done, o_err} !== 7'b1000000 ||
            o_status !== 64'd0 || o_status_src !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got rdy %0b busy %0b wen %0b ren %0b sv %0b done %0b expected rdy 1 others 0",
                     o_desc_ready, o_busy, o_reg_wen, o_reg_ren, o_status_valid, o_done);
        end
        repeat (3) tick;
        rst_n = 1'b1;
        clear_logs();
        repeat (20) tick;
        n_vec++;
        if (wlog.size() != 0 || rlog.size() != 0 || dlog.size() != 0 || o_desc_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_quiet: got writes %0d reads %0d done %0d ready %0b expected 0 0 0 1",
                     wlog.size(), rlog.size(), dlog.size(), o_desc_ready);
        end
        test_desc(0, 1'b1, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of run expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tx_stat = '0; rx_stat = '0; loss_stat = '0;
        test_reset();
        test_desc(1, 1'b1, 0);
        test_desc(1, 1'b0, 0);
        test_simultaneous();
        test_timeout();
        test_desc(0, 1'b1, 1);
        test_desc(0, 1'b0, 1);
        for (int k = 0; k < 4; k++) test_desc(0, 1'($urandom), 1'($urandom));
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
